// File: rtl/usb_ctrl_seq.sv
// usb_ctrl_seq: endpoint-0 control-transfer sequencer (SETUP parser, descriptor ROM, address/config commit).
// Optional feature macro: USB_CTRL_GET_STATUS_EN answers GET_STATUS with two zero bytes instead of STALL.
module usb_ctrl_seq #(
  parameter logic [15:0] VID = 16'h1209,
  parameter logic [15:0] PID = 16'h5bf0
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       usb_rst,
  input  logic       setup,
  input  logic       rx_strobe,
  input  logic [7:0] data_out,
  input  logic       tx_strobe,
  input  logic       status_ack,
  output logic [7:0] data_in,
  output logic       data_in_valid,
  output logic [1:0] handshake,
  output logic [6:0] dev_addr,
  output logic       configured
);
  typedef enum logic [2:0] {IDLE, SETUP_RX, DECODE, DATA_IN, STATUS, STALL} state_e;

  state_e      state_q, state_d;
  logic        setup_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  pkt_q [8];
  logic [7:0]  pkt_d [8];
  logic [5:0]  base_q, base_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rem_q, rem_d;
  logic        pend_addr_q, pend_addr_d;
  logic [6:0]  pend_val_q, pend_val_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        valid_q, valid_d;
  logic [6:0]  addr_q, addr_d;
  logic        cfg_q, cfg_d;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_byte;
  logic [15:0] w_length;
  logic [4:0]  desc_len;
  logic        setup_rise;

  assign setup_rise    = setup && !setup_q;
  assign w_length      = {pkt_q[7], pkt_q[6]};
  assign rom_addr      = base_q + 6'(idx_q);
  assign data_in       = data_in_q;
  assign data_in_valid = valid_q;
  assign dev_addr      = addr_q;
  assign configured    = cfg_q;
  assign handshake     = (state_q == STALL) ? 2'b11 : 2'b01;

  // Device descriptor at 0, config+interface at 18, GET_STATUS zeros at 36.
  always_comb begin
    case (rom_addr)
      6'd0:  rom_byte = 8'd18;
      6'd1:  rom_byte = 8'd1;
      6'd3:  rom_byte = 8'h02;
      6'd4:  rom_byte = 8'hFF;
      6'd7:  rom_byte = 8'd64;
      6'd8:  rom_byte = VID[7:0];
      6'd9:  rom_byte = VID[15:8];
      6'd10: rom_byte = PID[7:0];
      6'd11: rom_byte = PID[15:8];
      6'd13: rom_byte = 8'd1;
      6'd17: rom_byte = 8'd1;
      6'd18: rom_byte = 8'd9;
      6'd19: rom_byte = 8'd2;
      6'd20: rom_byte = 8'd18;
      6'd22: rom_byte = 8'd1;
      6'd23: rom_byte = 8'd1;
      6'd25: rom_byte = 8'h80;
      6'd26: rom_byte = 8'd50;
      6'd27: rom_byte = 8'd9;
      6'd28: rom_byte = 8'd4;
      6'd32: rom_byte = 8'hFF;
      default: rom_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pkt_d       = pkt_q;
    base_d      = base_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    pend_addr_d = pend_addr_q;
    pend_val_d  = pend_val_q;
    data_in_d   = data_in_q;
    valid_d     = 1'b0;
    addr_d      = addr_q;
    cfg_d       = cfg_q;
    desc_len    = '0;
    if (setup_rise || (state_q == IDLE && setup)) begin
      state_d = SETUP_RX;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SETUP_RX: begin
          if (!setup) begin
            state_d = IDLE;
          end else if (rx_strobe) begin
            pkt_d[cnt_q[2:0]] = data_out;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = DECODE;
          end
        end
        DECODE: begin
          state_d = STALL;
          idx_d   = '0;
          if (pkt_q[0] == 8'h80 && pkt_q[1] == 8'h06 && pkt_q[3] == 8'h01) begin
            base_d = 6'd0; desc_len = 5'd18; state_d = DATA_IN;
          end else if (pkt_q[0] == 8'h80 && pkt_q[1] == 8'h06 && pkt_q[3] == 8'h02) begin
            base_d = 6'd18; desc_len = 5'd18; state_d = DATA_IN;
`ifdef USB_CTRL_GET_STATUS_EN
          end else if ((pkt_q[0] inside {8'h80, 8'h81, 8'h82}) && pkt_q[1] == 8'h00) begin
            base_d = 6'd36; desc_len = 5'd2; state_d = DATA_IN;
`endif
          end else if (pkt_q[0] == 8'h00 && pkt_q[1] == 8'h05) begin
            pend_addr_d = 1'b1; pend_val_d = pkt_q[2][6:0]; state_d = STATUS;
          end else if (pkt_q[0] == 8'h00 && pkt_q[1] == 8'h09 && pkt_q[2][7:1] == 7'd0) begin
            pend_addr_d = 1'b0; pend_val_d = {6'd0, pkt_q[2][0]}; state_d = STATUS;
          end
          rem_d = (w_length < {11'd0, desc_len}) ? w_length[4:0] : desc_len;
        end
        DATA_IN: begin
          if (tx_strobe && !rx_strobe && rem_q != 5'd0) begin
            data_in_d = rom_byte;
            valid_d   = 1'b1;
            idx_d     = idx_q + 5'd1;
            rem_d     = rem_q - 5'd1;
          end
          if (status_ack) state_d = IDLE;
        end
        STATUS: begin
          if (status_ack) begin
            if (pend_addr_q) addr_d = pend_val_q;
            else             cfg_d  = pend_val_q[0];
            state_d = IDLE;
          end
        end
        STALL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48) begin
    if (!rst_n || usb_rst) begin
      state_q     <= IDLE;
      setup_q     <= 1'b0;
      cnt_q       <= '0;
      pkt_q       <= '{default: '0};
      base_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      pend_addr_q <= 1'b0;
      pend_val_q  <= '0;
      data_in_q   <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      cfg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_q     <= setup;
      cnt_q       <= cnt_d;
      pkt_q       <= pkt_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      pend_addr_q <= pend_addr_d;
      pend_val_q  <= pend_val_d;
      data_in_q   <= data_in_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      cfg_q       <= cfg_d;
    end
  end
endmodule

// File: tb/tb_usb_ctrl_seq.sv
// Directed self-checking bench for usb_ctrl_seq; honours USB_CTRL_GET_STATUS_EN if defined.
module tb_usb_ctrl_seq;
  logic       clk_48 = 1'b0;
  logic       rst_n, usb_rst, setup, rx_strobe, tx_strobe, status_ack;
  logic [7:0] data_out, data_in;
  logic       data_in_valid;
  logic [1:0] handshake;
  logic [6:0] dev_addr;
  logic       configured;
  int checks = 0;
  int errors = 0;
  logic       v;
  logic [7:0] d;

  logic [7:0] dev_rom [18] = '{8'd18, 8'h01, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'd64, 8'h09,
                               8'h12, 8'hF0, 8'h5B, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] cfg_rom [18] = '{8'd9, 8'd2, 8'd18, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'd50,
                               8'd9, 8'd4, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
  logic [7:0] st_rom  [18] = '{default: 8'h00};

  always #5 clk_48 = ~clk_48;

  usb_ctrl_seq #(.VID(16'h1209), .PID(16'h5bf0)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .usb_rst(usb_rst), .setup(setup),
    .rx_strobe(rx_strobe), .data_out(data_out), .tx_strobe(tx_strobe),
    .status_ack(status_ack), .data_in(data_in), .data_in_valid(data_in_valid),
    .handshake(handshake), .dev_addr(dev_addr), .configured(configured)
  );

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte 0 of the SETUP packet is pkt[63:56]; n < 8 drops setup early.
  task automatic send_setup(input logic [63:0] pkt, input int unsigned n);
    setup = 1'b1;
    tick();
    for (int unsigned i = 0; i < n; i++) begin
      data_out  = pkt[63 - 8*i -: 8];
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      tick();
    end
    setup = 1'b0;
    tick();
  endtask

  task automatic read_in(output logic ov, output logic [7:0] od);
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    ov = data_in_valid;
    od = data_in;
    tick();
  endtask

  task automatic read_check(input string tag, input int unsigned n, input logic [7:0] rom [18],
                            input int unsigned expn);
    logic       rv;
    logic [7:0] rd;
    for (int unsigned i = 0; i < n; i++) begin
      read_in(rv, rd);
      if (i < expn) begin
        chk($sformatf("%s_valid%0d", tag, i), 16'(rv), 16'd1);
        chk($sformatf("%s_byte%0d", tag, i), 16'(rd), 16'(rom[i]));
      end else begin
        chk($sformatf("%s_novalid%0d", tag, i), 16'(rv), 16'd0);
      end
    end
  endtask

  task automatic ack();
    status_ack = 1'b1;
    tick();
    status_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; usb_rst = 1'b0; setup = 1'b0; rx_strobe = 1'b0;
    tx_strobe = 1'b0; status_ack = 1'b0; data_out = 8'h00;
    repeat (3) tick();
    chk("rst_data_in", 16'(data_in), 16'h00);
    chk("rst_valid", 16'(data_in_valid), 16'd0);
    chk("rst_handshake", 16'(handshake), 16'b01);
    chk("rst_dev_addr", 16'(dev_addr), 16'd0);
    chk("rst_configured", 16'(configured), 16'd0);
    rst_n = 1'b1;
    tick();

    send_setup(64'h80_06_00_01_00_00_40_00, 8);
    chk("getdesc_hs", 16'(handshake), 16'b01);
    read_check("dev", 20, dev_rom, 18);
    chk("valid_pulse", 16'(data_in_valid), 16'd0);
    ack();

    send_setup(64'h80_06_00_01_00_00_08_00, 8);
    read_check("dev8", 10, dev_rom, 8);
    ack();

    send_setup(64'h80_06_00_02_00_00_05_01, 8);
    read_check("cfg", 20, cfg_rom, 18);
    ack();

    send_setup(64'h80_06_00_01_00_00_00_00, 8);
    read_check("len0", 2, dev_rom, 0);
    ack();

    send_setup(64'h00_05_2A_00_00_00_00_00, 8);
    read_in(v, d);
    chk("tx_in_status", 16'(v), 16'd0);
    chk("addr_before_ack", 16'(dev_addr), 16'd0);
    ack();
    chk("addr_after_ack", 16'(dev_addr), 16'h2A);
    usb_rst = 1'b1;
    tick();
    usb_rst = 1'b0;
    tick();
    chk("addr_usb_rst", 16'(dev_addr), 16'd0);

    send_setup(64'h00_09_01_00_00_00_00_00, 8);
    chk("cfg_before_ack", 16'(configured), 16'd0);
    ack();
    chk("cfg_after_ack", 16'(configured), 16'd1);

    send_setup(64'h80_0A_00_00_00_00_01_00, 8);
    chk("stall_hs", 16'(handshake), 16'b11);
    repeat (4) tick();
    ack();
    chk("stall_hold", 16'(handshake), 16'b11);
    setup = 1'b1;
    tick();
    chk("stall_exit", 16'(handshake), 16'b01);
    send_setup(64'h00_09_02_00_00_00_00_00, 8);
    chk("cfg2_stall", 16'(handshake), 16'b11);

    send_setup(64'h00_05_33_00_00_00_00_00, 5);
    chk("abort_hs", 16'(handshake), 16'b01);
    chk("abort_addr", 16'(dev_addr), 16'd0);
    chk("abort_cfg", 16'(configured), 16'd1);
    ack();
    chk("abort_addr_ack", 16'(dev_addr), 16'd0);

    send_setup(64'h00_05_44_00_00_00_00_00, 8);
    send_setup(64'h80_06_00_01_00_00_40_00, 8);
    ack();
    chk("drop_pending", 16'(dev_addr), 16'd0);

    send_setup(64'h80_06_00_01_00_00_40_00, 8);
    read_check("pre_restart", 3, dev_rom, 3);
    send_setup(64'h80_06_00_01_00_00_40_00, 8);
    read_in(v, d);
    chk("restart_valid", 16'(v), 16'd1);
    chk("restart_byte0", 16'(d), 16'd18);
    ack();

    send_setup(64'h00_05_55_00_00_00_00_00, 8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ack();
    chk("rst_mid_addr", 16'(dev_addr), 16'd0);
    chk("rst_mid_cfg", 16'(configured), 16'd0);

    send_setup(64'h80_00_00_00_00_00_02_00, 8);
`ifdef USB_CTRL_GET_STATUS_EN
    chk("getstatus_hs", 16'(handshake), 16'b01);
    read_check("getstatus", 3, st_rom, 2);
    ack();
`else
    chk("getstatus_stall", 16'(handshake), 16'b11);
    read_check("getstatus", 1, st_rom, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
